// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_RDY  = 2'd3
  } arb_state_t;

  // Next requester index after idx, wrapping at n rather than at 2**IDX_W.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int unsigned n);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
    if (32'(sum) >= n) begin
      return {IDX_W{1'b0}};
    end else begin
      return sum[IDX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int CW = IDX_W + 1;

  logic [NREQ-1:0] rot_s;
  logic [CW-1:0]   cand_s;

  // Rotate so bit 0 is the ptr position, then take the lowest set bit.
  always_comb begin
    rot_s  = NREQ'({req, req} >> ptr);
    idx    = {IDX_W{1'b0}};
    any    = 1'b0;
    cand_s = {CW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr} + CW'(k);
      if (cand_s >= CW'(NREQ)) begin
        cand_s = cand_s - CW'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!any && rot_s[k]) begin
        idx = cand_s[IDX_W-1:0];
        any = 1'b1;
      end else begin
        any = any;
      end
    end
    if (any) begin
      gnt = NREQ'(1'b1) << idx;
    end else begin
      gnt = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter sharing one UART transmitter among NREQ byte streams,
// with an idle timeout that releases a stalled owner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        txdin,
  output logic              txgo,
  input  logic              txrdy,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_err,
  output logic [2:0]        timeout_id
);

  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic            TO_EN   = (TIMEOUT != 0);

  arb_state_t       state_r, state_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [IDX_W-1:0] own_r, own_s;
  logic [NREQ-1:0]  grant_r, grant_s;
  logic             busy_r, busy_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       txdin_r, txdin_s;
  logic             txgo_r, txgo_s;
  logic             last_r, last_s;
  logic             terr_r, terr_s;
  logic [IDX_W-1:0] tid_r, tid_s;
  logic [NREQ-1:0]  req_ready_s;

  logic [NREQ-1:0]  pick_gnt_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             own_valid_s;
  logic             own_last_s;
  logic [7:0]       own_byte_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // The one-hot grant doubles as the owner mask, avoiding narrow-vector indexing.
  assign own_valid_s = |(req_valid & grant_r);
  assign own_last_s  = |(req_last & grant_r);
  assign own_byte_s  = 8'(req_data >> {own_r, 3'b000});

  // Next-state and datapath update for the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    own_s       = own_r;
    grant_s     = grant_r;
    busy_s      = busy_r;
    cnt_s       = cnt_r;
    txdin_s     = txdin_r;
    txgo_s      = 1'b0;
    last_s      = last_r;
    terr_s      = 1'b0;
    tid_s       = tid_r;
    req_ready_s = {NREQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          own_s   = pick_idx_s;
          grant_s = pick_gnt_s;
          busy_s  = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        // An owner byte arriving in the timeout cycle wins over the release.
        if (own_valid_s && txrdy) begin
          req_ready_s = grant_r;
          txdin_s     = own_byte_s;
          last_s      = own_last_s;
          txgo_s      = 1'b1;
          cnt_s       = {CNT_W{1'b0}};
          state_s     = WAIT_BUSY;
        end else if (!own_valid_s && TO_EN && (cnt_r == CNT_LIM)) begin
          terr_s  = 1'b1;
          tid_s   = own_r;
          ptr_s   = wrap_inc(own_r, NREQ);
          grant_s = {NREQ{1'b0}};
          busy_s  = 1'b0;
          cnt_s   = {CNT_W{1'b0}};
          state_s = IDLE;
        end else if (!own_valid_s && (cnt_r != CNT_MAX)) begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_s = cnt_r;
        end
      end
      WAIT_BUSY: begin
        if (!txrdy) begin
          state_s = WAIT_RDY;
        end else begin
          state_s = WAIT_BUSY;
        end
      end
      WAIT_RDY: begin
        if (txrdy && last_r) begin
          ptr_s   = wrap_inc(own_r, NREQ);
          grant_s = {NREQ{1'b0}};
          busy_s  = 1'b0;
          state_s = IDLE;
        end else if (txrdy) begin
          state_s = SEND;
        end else begin
          state_s = WAIT_RDY;
        end
      end
      default: begin
        grant_s = {NREQ{1'b0}};
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      ptr_r   <= {IDX_W{1'b0}};
      own_r   <= {IDX_W{1'b0}};
      grant_r <= {NREQ{1'b0}};
      busy_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      txdin_r <= 8'h00;
      txgo_r  <= 1'b0;
      last_r  <= 1'b0;
      terr_r  <= 1'b0;
      tid_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      own_r   <= own_s;
      grant_r <= grant_s;
      busy_r  <= busy_s;
      cnt_r   <= cnt_s;
      txdin_r <= txdin_s;
      txgo_r  <= txgo_s;
      last_r  <= last_s;
      terr_r  <= terr_s;
      tid_r   <= tid_s;
    end
  end

  assign req_ready   = req_ready_s;
  assign txdin       = txdin_r;
  assign txgo        = txgo_r;
  assign grant       = grant_r;
  assign busy        = busy_r;
  assign timeout_err = terr_r;
  assign timeout_id  = tid_r;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locking arbiter that shares the single `uart` transmitter among `NREQ` byte-stream requesters (command responder, debug logger, status reporter, ...). It sits between the requesters and the `uart` TX side. It drives `txdin`/`txgo` and watches `txrdy`. A grant is held from a packet's first byte until the byte flagged `last`. An idle-timeout releases the grant if the owner stalls mid-packet.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: cycles a granted requester may leave `req_valid` low mid-packet before forced release. 0 disables the timeout.

Ports:
- `clk`  in  1  main clock, drives all logic.
- `rst`  in  1  asynchronous reset, active-low.
- `req_valid`  in  NREQ  requester i has a byte on `req_data[8*i+7:8*i]`.
- `req_data`  in  8*NREQ  packed bytes.
- `req_last`  in  NREQ  the byte offered by requester i ends its packet.
- `req_ready`  out  NREQ  one-hot, 1-cycle accept strobe.
- `txdin`  out  8  byte to `uart`; registered.
- `txgo`  out  1  1-cycle start pulse to `uart`; registered.
- `txrdy`  in  1  `uart` transmitter ready.
- `grant`  out  NREQ  one-hot current owner; 0 when idle.
- `busy`  out  1  a packet is in progress.
- `timeout_err`  out  1  1-cycle pulse on forced release.
- `timeout_id`  out  3  index of the released requester; held until the next timeout.

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_RDY.
- **IDLE**: if any `req_valid` is high, pick the owner by round robin, searching upward from pointer `ptr` and wrapping.
  - Set `grant` to the owner and `busy`=1, then go to SEND.
  - If no `req_valid` is high, stay in IDLE.
- **SEND**, owner g:
  - If `req_valid[g]` and `txrdy` are both high, `req_ready[g]`=1 combinationally in that cycle.
  - In the same cycle, `txdin` <= byte and `last_q` <= `req_last[g]`.
  - `txgo` is 1 on the next cycle only, and the state moves to WAIT_BUSY.
  - If `req_valid[g]` is low, the idle counter increments; it resets to 0 on every accept.
  - When the counter equals `TIMEOUT` (and `TIMEOUT` is not 0): pulse `timeout_err`, set `timeout_id`=g, set `ptr`=g+1 mod NREQ, clear `grant` and `busy`, and go to IDLE.
- **WAIT_BUSY**: wait for `txrdy`=0. `uart` drops `txrdy` in the cycle after `txgo`.
- **WAIT_RDY**: wait for `txrdy`=1.
  - If `last_q`=1: set `ptr`=g+1 mod NREQ, clear `grant` and `busy`, go to IDLE.
  - If `last_q`=0: go to SEND.
- Non-owners never see `req_ready`. Their requests wait and are not dropped.
- A requester may drop `req_valid` without being accepted. This is not an error; only the owner's idle counter runs.
- A single-byte packet is a byte with `last`=1 on its first byte.
- Round-robin fairness: after owner g finishes, requester g has the lowest priority.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE, `ptr`=0, counter 0.
  - `txdin`=0, `txgo`=0, `grant`=0, `busy`=0.
  - `req_ready`=0, `timeout_err`=0, `timeout_id`=0.
- Reset mid-packet abandons the packet. A byte already handed to `uart` completes, or not, according to the `uart`'s own reset.
- Latency with `txrdy` high:
  - `req_valid` rising in IDLE gives `grant` at cycle +1.
  - `req_ready` follows at cycle +1, in SEND, combinationally.
  - `txgo` follows at cycle +2.
- Minimum overhead per byte: 3 cycles plus the `uart` frame time. The next byte of the same packet can be accepted in the cycle after `txrdy` returns high.
- Event in the same cycle as a timeout:
  - `req_valid[g]` rising in that cycle wins; the counter compare uses the value before the increment.
  - `ptr` update and release happen in the same cycle as the `timeout_err` pulse.
- If `txrdy` is low while in SEND (`uart` busy at grant time), hold SEND without accepting. The idle counter still runs only on low `req_valid[g]`.
- Index widths: `ptr` and `timeout_id` are 3 bits. The wrap is mod NREQ, not mod 8.
- The counter is `$clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.

## Structure
- Package `uart_arb_pkg`: state enum (IDLE, SEND, WAIT_BUSY, WAIT_RDY), `MAX_REQ`=8, index width constant.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot `gnt`, binary `idx`, `any`.
  - Reused for a future RX-side router.
- The top level holds the FSM, datapath registers and timeout counter. Target size is about 200 lines.

## Test plan
- Single requester: req0 sends 0x55, 0xAA (`last`). Required: `txgo` pulses twice with `txdin` 0x55 then 0xAA, `grant`=0001 throughout, then `busy`=0.
- Contention: req1 and req2 valid in the same cycle with `ptr`=0. Required: req1 is served first. After its `last` byte, `grant`=0100 with no intervening IDLE wait beyond 1 cycle.
- Packet lock: req3 raises valid during req0's 3-byte packet. Required: no `req_ready[3]` until req0's `last` byte completes, and the bytes on `txdin` are not interleaved.
- Timeout: `TIMEOUT`=16; req2 sends 1 byte without `last`, then drops valid. Required:
  - `timeout_err` pulses exactly 16 cycles after SEND is re-entered.
  - `timeout_id`=2, `grant`=0.
  - A pending req3 is granted next.
- Slow `uart`: `txrdy` held low for 50 cycles at grant. Required: the owner is not accepted until `txrdy`=1, and exactly one `txgo` pulse follows.
- Reset mid-packet: assert `rst`=0 in WAIT_RDY. Required: all outputs are 0 immediately (asynchronous). After release, state is IDLE and `ptr`=0.
